// File: rtl/cdc_hs_pkg.sv
// cdc_hs_pkg: shared types and default constants for the req/ack handshake
// transmitter (cdc_hs_tx) and its ack synchronizer.
package cdc_hs_pkg;

    // Handshake phases seen from the sending side
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } cdc_hs_state_e;

    localparam int CDC_HS_DATA_WIDTH  = 8;
    localparam int CDC_HS_SYNC_STAGES = 2;

endpackage

// File: rtl/ack_sync.sv
// ack_sync: SYNC_STAGES-deep flop chain that brings the receiver's
// asynchronous ack into the clk domain. Resets to 0 so a stale ack is
// re-sampled from scratch after reset.
module ack_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync;

    // Shift the raw ack through the chain; only the last flop is used
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], d};
    end

    assign q = sync[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: sending end of a four-phase req/ack handshake. A word is taken
// on tx_valid/tx_ready, held on data_out, and announced by req_out; the cycle
// ends once the synchronized ack has risen and fallen again.
// Optional feature macro: CDC_HS_TX_TIMEOUT_EN (REQ_HI ack-wait timeout, tx_err).
module cdc_hs_tx
    import cdc_hs_pkg::*;
#(
    parameter int DATA_WIDTH     = CDC_HS_DATA_WIDTH,
    parameter int SYNC_STAGES    = CDC_HS_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  tx_done,
    output logic                  req_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ack_in
`ifdef CDC_HS_TX_TIMEOUT_EN
    ,
    output logic                  tx_err
`endif
);

    // Parameter legality, caught at elaboration
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("cdc_hs_tx: SYNC_STAGES must be 2..4");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cdc_hs_tx: TIMEOUT_CYCLES must be >= 1");
    end

    cdc_hs_state_e state;
    logic          ack_s;

    ack_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_in),
        .q   (ack_s)
    );

    // A lingering ack in IDLE (e.g. from before reset) must clear before a
    // new word is taken, otherwise the next handshake would complete early.
    assign tx_ready = (state == IDLE) && !ack_s;

`ifdef CDC_HS_TX_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;

    // Handshake FSM with data register, ack-wait counter and registered pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            req_out  <= 1'b0;
            data_out <= '0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        data_out <= tx_data;
                        req_out  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (ack_s) begin
                        req_out <= 1'b0;
                        state   <= REQ_LO;
                    end else if (wait_cnt == CNT_LAST) begin
                        // Give up on the receiver; still wait for ack low so
                        // the handshake closes cleanly with tx_done
                        tx_err  <= 1'b1;
                        req_out <= 1'b0;
                        state   <= REQ_LO;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                REQ_LO: begin
                    if (!ack_s) begin
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    req_out <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
`else
    // Handshake FSM with data register and registered done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            req_out  <= 1'b0;
            data_out <= '0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        data_out <= tx_data;
                        req_out  <= 1'b1;
                        state    <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (ack_s) begin
                        req_out <= 1'b0;
                        state   <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (!ack_s) begin
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    req_out <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb_cdc_hs_tx: directed bench for cdc_hs_tx at default width/sync depth,
// TIMEOUT_CYCLES=10. Timeout sequence runs only with CDC_HS_TX_TIMEOUT_EN.
module tb_cdc_hs_tx;

    logic       clk;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       req_out;
    logic [7:0] data_out;
    logic       ack_in;
`ifdef CDC_HS_TX_TIMEOUT_EN
    logic       tx_err;
`endif

    int checks   = 0;
    int failures = 0;

    cdc_hs_tx #(
        .DATA_WIDTH     (8),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .req_out  (req_out),
        .data_out (data_out),
        .ack_in   (ack_in)
`ifdef CDC_HS_TX_TIMEOUT_EN
        ,
        .tx_err   (tx_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and act as a receiver that mirrors req_out onto ack_in
    task automatic send_word(input logic [7:0] w, input string nm);
        int  n;
        int  ndone;
        tx_valid = 1'b1;
        tx_data  = w;
        n = 0;
        while (!tx_ready && n < 50) begin
            tick();
            n++;
        end
        chk({nm, "_ready"}, tx_ready, 1);
        tick();
        tx_valid = 1'b0;
        tx_data  = ~w;
        chk({nm, "_req"}, req_out, 1);
        chk({nm, "_data"}, data_out, w);
        ndone = 0;
        n = 0;
        while (ndone == 0 && n < 60) begin
            ack_in = req_out;
            tick();
            n++;
            if (req_out) chk({nm, "_hold"}, data_out, w);
            if (tx_done) ndone++;
        end
        chk({nm, "_done"}, ndone, 1);
        chk({nm, "_ready_after"}, tx_ready, 1);
        ack_in = 1'b0;
    endtask

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic       ack;
        logic       e_rdy;
        logic       e_req;
        logic       e_done;
        logic [7:0] e_dat;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [7:0] bw [3];
        int         nacc;
        int         ndone;
        logic       prev;

        // Single transfer of A5: receiver acks 1 cycle after req rises and
        // drops 1 cycle after req falls; tx_data scribbled while busy.
        //          vld   dat    ack   rdy   req   done  data
        vt[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
        vt[1] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
        vt[2] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
        vt[3] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
        vt[4] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
        vt[5] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
        vt[6] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
        vt[7] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
        vt[8] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
        vt[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};

        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        ack_in   = 1'b0;

        // Reset asserted mid-cycle: outputs clear without a clock edge
        #3 rst = 1'b1;
        #1;
        chk("rst_req", req_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_done", tx_done, 0);
`ifdef CDC_HS_TX_TIMEOUT_EN
        chk("rst_err", tx_err, 0);
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_req", req_out, 0);
        chk("post_rst_ready", tx_ready, 1);
        chk("post_rst_done", tx_done, 0);

        // Table-driven single transfer
        for (int i = 0; i < 10; i++) begin
            tx_valid = vt[i].vld;
            tx_data  = vt[i].dat;
            ack_in   = vt[i].ack;
            tick();
            chk($sformatf("vec%0d_ready", i), tx_ready, vt[i].e_rdy);
            chk($sformatf("vec%0d_req", i), req_out, vt[i].e_req);
            chk($sformatf("vec%0d_done", i), tx_done, vt[i].e_done);
            chk($sformatf("vec%0d_data", i), data_out, vt[i].e_dat);
        end

        // Back-to-back: tx_valid held across three words
        bw[0] = 8'h01;
        bw[1] = 8'h02;
        bw[2] = 8'h03;
        nacc  = 0;
        ndone = 0;
        prev  = req_out;
        tx_valid = 1'b1;
        tx_data  = bw[0];
        for (int c = 0; c < 200 && ndone < 3; c++) begin
            ack_in = req_out;
            tick();
            if (req_out && !prev) begin
                if (nacc < 3) chk("b2b_word", data_out, bw[nacc]);
                nacc++;
                if (nacc < 3) tx_data = bw[nacc];
                else          tx_valid = 1'b0;
            end else if (req_out && nacc > 0 && nacc <= 3) begin
                chk("b2b_hold", data_out, bw[nacc-1]);
            end
            if (tx_done) begin
                chk("b2b_ready_done", tx_ready, 1);
                ndone++;
            end else begin
                chk("b2b_ready_busy", tx_ready, 0);
            end
            prev = req_out;
        end
        chk("b2b_accepts", nacc, 3);
        chk("b2b_dones", ndone, 3);
        tx_valid = 1'b0;
        ack_in   = 1'b0;
        tick();

        // Stale ack held through reset release blocks acceptance
        ack_in = 1'b1;
        #4 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("stale_ready", tx_ready, 0);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stale_req", req_out, 0);
            chk("stale_blocked", tx_ready, 0);
        end
        ack_in = 1'b0;
        tick();
        chk("stale_clearing", tx_ready, 0);
        tick();
        chk("stale_cleared", tx_ready, 1);
        send_word(8'h3C, "stale_xfer");

        // Reset pulse while in REQ_HI
        tick();
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        tick();
        tx_valid = 1'b0;
        chk("mid_req_up", req_out, 1);
        ack_in = 1'b1;
        tick();
        chk("mid_still_hi", req_out, 1);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_req", req_out, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_done", tx_done, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_no_done", tx_done, 0);
            chk("mid_no_req", req_out, 0);
        end
        ack_in = 1'b0;
        send_word(8'h96, "mid_next");

`ifdef CDC_HS_TX_TIMEOUT_EN
        // Receiver never answers: tx_err after 10 cycles in REQ_HI
        tick();
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        ack_in   = 1'b0;
        tick();
        tx_valid = 1'b0;
        chk("to_req_up", req_out, 1);
        for (int k = 1; k < 10; k++) begin
            tick();
            chk("to_wait_err", tx_err, 0);
            chk("to_wait_req", req_out, 1);
        end
        tick();
        chk("to_err", tx_err, 1);
        chk("to_req_drop", req_out, 0);
        chk("to_err_no_done", tx_done, 0);
        tick();
        chk("to_done", tx_done, 1);
        chk("to_err_clear", tx_err, 0);
        chk("to_ready", tx_ready, 1);
        chk("to_data", data_out, 8'hC3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdc_hs_tx.md
# cdc_hs_tx

Sending end of a four-phase req/ack handshake that carries a DATA_WIDTH-bit word from this clock domain to a receiver in an unrelated domain. A word is accepted on a valid/ready handshake, held stable on data_out, and announced by raising req_out. The receiver's asynchronous ack_in is synchronized internally, and the cycle completes once ack returns low. This block is the transmit counterpart of the team's input synchronizers; the receiver samples req_out through its own synchronizer.

## Interface
- DATA_WIDTH, 8: width of transferred word.
- SYNC_STAGES, 2: flops in the ack_in synchronizer chain; legal range 2–4.
- TIMEOUT_CYCLES, 255: ack wait limit; only used when CDC_HS_TX_TIMEOUT_EN is defined.
- clk  input  1  single clock; all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_valid  input  1  word on tx_data is offered.
- tx_data  input  DATA_WIDTH  word to send.
- tx_ready  output  1  block can accept a word this cycle.
- tx_done  output  1  one-cycle pulse when a handshake completes.
- req_out  output  1  registered request to the receiver domain.
- data_out  output  DATA_WIDTH  registered word, stable whenever req_out=1.
- ack_in  input  1  asynchronous acknowledge from the receiver.
- tx_err  output  1  one-cycle timeout pulse; present only with CDC_HS_TX_TIMEOUT_EN.

## Operation
- Reset values: state IDLE; req_out=0, data_out=0, tx_done=0, tx_err=0; all synchronizer flops 0. tx_ready is 1 once the synchronized ack (ack_s) is 0.
- ack_s is the output of a SYNC_STAGES-deep flop chain on ack_in. The FSM uses only ack_s.
- tx_ready = (state==IDLE) && !ack_s. This is combinational from registers only, with no dependence on tx_valid.
- IDLE: when tx_valid && tx_ready, latch tx_data into data_out, set req_out=1, go to REQ_HI.
- REQ_HI: hold req_out=1 and data_out. When ack_s=1, set req_out=0 and go to REQ_LO.
- REQ_LO: hold data_out. When ack_s=0, pulse tx_done and go to IDLE.
- data_out changes only on acceptance. Changes on tx_data while not in IDLE are ignored.
- While ack_s=1 in IDLE, a stale ack (e.g. after reset) blocks acceptance until it clears. This prevents a spurious completion.
- Reset mid-handshake: req_out drops asynchronously, the FSM enters IDLE, and no tx_done pulse is produced.

## Timing
- Accept at rising edge N (tx_valid && tx_ready sampled): data_out and req_out are valid after edge N; tx_ready is low from N.
- An ack_in rising edge is seen as ack_s=1 after SYNC_STAGES edges. req_out falls on the next edge after that.
- An ack_in falling edge is likewise seen after SYNC_STAGES edges. tx_done is high for the cycle following the edge where REQ_LO sees ack_s=0; tx_ready is high in that same cycle.
- Minimum accept-to-done with an instantly responding receiver and zero ack delay is 2·SYNC_STAGES+2 cycles (6 at default).
- Throughput is at most one word per handshake. Back-to-back tx_valid is accepted in the cycle tx_done pulses.

## Configuration
- CDC_HS_TX_TIMEOUT_EN defined:
  - An 8-bit-minimum counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry to REQ_HI and increments each cycle spent there.
  - When it reaches TIMEOUT_CYCLES with ack_s still 0: pulse tx_err, drop req_out, go to REQ_LO. The normal wait for ack_s=0 then applies, so tx_done still pulses.
  - The timeout applies to REQ_HI only.
- CDC_HS_TX_TIMEOUT_EN not defined: no counter and no tx_err port. REQ_HI waits indefinitely.

## Structure
- Package cdc_hs_pkg holds:
  - the state typedef: enum logic [1:0] {IDLE, REQ_HI, REQ_LO};
  - default constants CDC_HS_DATA_WIDTH=8 and CDC_HS_SYNC_STAGES=2.
- Sub-module ack_sync: parameterized SYNC_STAGES flop chain with asynchronous active-high reset to 0, instantiated once for ack_in.
- The FSM, data register and optional timeout counter live in cdc_hs_tx.

## Test plan
- Reset: assert rst mid-cycle with ack_in=0 → req_out=0, data_out=0, tx_ready=1, tx_done=0 immediately and after release.
- Single transfer: tx_data=8'hA5 with tx_valid for one cycle; bench acks 1 cycle after req_out rises and drops 1 cycle after req_out falls → data_out=8'hA5 stable throughout the req_out-high interval; exactly one tx_done pulse; tx_ready low until then.
- Back-to-back: hold tx_valid with words 8'h01, 8'h02, 8'h03 → three handshakes in order, each data_out matching, tx_ready high only in the tx_done cycles, no word lost or repeated.
- Stale ack: hold ack_in=1 through reset release, then offer 8'h3C → tx_ready stays 0 and req_out stays 0 until ack_s clears; transfer then proceeds normally.
- Reset mid-handshake: pulse rst while in REQ_HI → req_out=0 asynchronously, no tx_done; the next word is sent correctly after the bench drops ack.
- Timeout (macro defined, TIMEOUT_CYCLES=10): never assert ack_in → tx_err pulses 10 cycles after entering REQ_HI, req_out falls, tx_done follows one cycle later, tx_ready returns to 1.
